pipelined_divider: RTL
======================

# pipelined_divider

Fully pipelined integer divider with a valid/ready handshake, selectable signed/unsigned mode per request, quotient and remainder outputs, and defined results for divide-by-zero and signed overflow. It is the parametrised successor to the fixed-latency signed divide wrapper. It sits in the accelerator datapath wherever a producer issues one division per cycle and the consumer may apply backpressure. Each request carries a tag that is returned unchanged with its result.

## Interface
- DATA_LEN, 32: operand, quotient and remainder width; legal range ≥ 2.
- TAG_LEN, 8: width of the opaque request tag; legal range ≥ 1.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_signed  in  1  1: two's-complement operands; 0: unsigned.
- in_a  in  DATA_LEN  dividend.
- in_b  in  DATA_LEN  divisor.
- in_tag  in  TAG_LEN  request tag.
- out_valid  out  1  result present.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_quot  out  DATA_LEN  quotient.
- out_rem  out  DATA_LEN  remainder.
- out_tag  out  TAG_LEN  tag of this result.
- out_dbz  out  1  divisor was zero.
- out_ovf  out  1  signed overflow (MIN / -1).

## Operation
- Pipeline has LATENCY = DATA_LEN + 2 register stages:
  - Stage 0 (prep): in signed mode, take absolute values of operands; record quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a); detect dbz and ovf.
  - Stages 1..DATA_LEN: restoring division, one quotient bit per stage, MSB first, on unsigned magnitudes held in DATA_LEN+1-bit partial remainders.
  - Final stage (fix): negate quotient and/or remainder per recorded signs; apply special-case overrides; register the outputs.
- Each stage carries a valid bit, tag, mode, signs and flags alongside its data.
- Arithmetic rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend; a = q*b + r always holds, modulo 2^DATA_LEN.
  - Unsigned mode treats all bits as magnitude; no sign handling is applied.
- Divide by zero, either mode:
  - quot = all ones;
  - rem = in_a unchanged;
  - out_dbz = 1; out_ovf = 0.
- Signed overflow (in_signed = 1, a = -2^(DATA_LEN-1), b = -1):
  - quot = a;
  - rem = 0;
  - out_ovf = 1; out_dbz = 0.
- out_dbz and out_ovf are never both 1 for the same result.
- Flow control:
  - advance = !out_valid || out_ready.
  - When advance = 1, every stage shifts forward by one.
  - When advance = 0, every stage holds, including bubbles.
- in_ready = advance && !reset. A request is captured only when in_valid && in_ready.
- No reordering: results leave in acceptance order.

## Timing
- Reset values:
  - in_ready = 0 while reset is high;
  - out_valid = 0; out_quot = 0; out_rem = 0; out_tag = 0; out_dbz = 0; out_ovf = 0;
  - all stage valid bits = 0.
- Reset mid-operation discards all in-flight requests. No result appears for them after reset deasserts.
- First cycle after reset deasserts: in_ready = 1.
- Latency: a request accepted at edge N, with no stalls, has out_valid = 1 after edge N + LATENCY. Default LATENCY = 34.
- Throughput: one request per cycle while out_ready = 1.
- Stalls:
  - A stall of k cycles delays every in-flight result by exactly k cycles.
  - Outputs stay stable while out_valid && !out_ready.
- Simultaneous accept and output handshake in the same cycle is legal and is the steady-state case.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid to out_*.

## Test plan
- Reset, then unsigned 100 / 7, tag 0x11 -> after 34 cycles: quot 14, rem 2, tag 0x11, flags 0.
- Signed -7 / 2, then 7 / -2, back-to-back -> quot -3 / rem -1, then quot -3 / rem 1; results on consecutive cycles, in order.
- 0x80000000 / 0xFFFFFFFF:
  - signed -> quot 0x80000000, rem 0, out_ovf = 1.
  - unsigned -> quot 0, rem 0x80000000, flags 0.
- 1234 / 0, signed and unsigned -> quot 0xFFFFFFFF, rem 1234, out_dbz = 1.
- Stream 100 random requests with random out_ready deassertion -> all results match the reference model, in order; outputs hold while stalled; no drop or duplicate.
- Assert reset with 10 requests in flight -> out_valid = 0 next cycle; none of the 10 results ever appear; a new request completes after 34 cycles.

Source files
------------

// File: rtl/pipelined_divider.sv
// Fully pipelined restoring divider with a valid/ready handshake, signed/unsigned mode per request,
// tag passthrough and defined divide-by-zero / signed-overflow results.
module pipelined_divider #(
    parameter int DATA_LEN = 32,
    parameter int TAG_LEN  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_signed,
    input  logic [DATA_LEN-1:0] in_a,
    input  logic [DATA_LEN-1:0] in_b,
    input  logic [TAG_LEN-1:0]  in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_quot,
    output logic [DATA_LEN-1:0] out_rem,
    output logic [TAG_LEN-1:0]  out_tag,
    output logic                out_dbz,
    output logic                out_ovf
);

    typedef struct packed {
        logic                valid;
        logic [TAG_LEN-1:0]  tag;
        logic                qneg;
        logic                rneg;
        logic                dbz;
        logic                ovf;
        logic [DATA_LEN-1:0] a_raw;
        logic [DATA_LEN-1:0] b_mag;
        logic [DATA_LEN-1:0] q;
        logic [DATA_LEN-1:0] r;
    } stage_t;

    localparam logic [DATA_LEN-1:0] MIN_VAL  = {1'b1, {(DATA_LEN-1){1'b0}}};
    localparam logic [DATA_LEN-1:0] ALL_ONES = {DATA_LEN{1'b1}};
    localparam logic [DATA_LEN-1:0] ZERO_VAL = {DATA_LEN{1'b0}};

    logic                advance_s;
    logic                cap_valid_r;
    logic                cap_signed_r;
    logic [DATA_LEN-1:0] cap_a_r;
    logic [DATA_LEN-1:0] cap_b_r;
    logic [TAG_LEN-1:0]  cap_tag_r;
    stage_t              stage_r [0:DATA_LEN];
    stage_t              next_s  [0:DATA_LEN];
    logic [DATA_LEN-1:0] fix_quot_s;
    logic [DATA_LEN-1:0] fix_rem_s;
    logic [TAG_LEN-1:0]  fix_tag_s;
    logic                fix_valid_s;
    logic                fix_dbz_s;
    logic                fix_ovf_s;

    // The whole pipe moves in lockstep; a stalled output freezes every stage, bubbles included.
    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s && !reset;

    // Prep stage (magnitudes, signs, special cases) followed by one restoring-division step per stage.
    always_comb begin
        logic                a_neg_v;
        logic                b_neg_v;
        logic [DATA_LEN:0]   shifted_v;
        logic [DATA_LEN:0]   diff_v;
        a_neg_v   = cap_signed_r && cap_a_r[DATA_LEN-1];
        b_neg_v   = cap_signed_r && cap_b_r[DATA_LEN-1];
        shifted_v = {(DATA_LEN+1){1'b0}};
        diff_v    = {(DATA_LEN+1){1'b0}};
        next_s[0]       = '0;
        next_s[0].valid = cap_valid_r;
        next_s[0].tag   = cap_tag_r;
        next_s[0].qneg  = a_neg_v ^ b_neg_v;
        next_s[0].rneg  = a_neg_v;
        next_s[0].dbz   = (cap_b_r == ZERO_VAL);
        next_s[0].ovf   = cap_signed_r && (cap_a_r == MIN_VAL) && (cap_b_r == ALL_ONES);
        next_s[0].a_raw = cap_a_r;
        next_s[0].b_mag = b_neg_v ? (ZERO_VAL - cap_b_r) : cap_b_r;
        next_s[0].q     = a_neg_v ? (ZERO_VAL - cap_a_r) : cap_a_r;
        next_s[0].r     = ZERO_VAL;
        // q starts as the dividend magnitude and is shifted out MSB first while quotient bits shift in.
        for (int i = 1; i <= DATA_LEN; i++) begin
            next_s[i] = stage_r[i-1];
            shifted_v = {stage_r[i-1].r, stage_r[i-1].q[DATA_LEN-1]};
            diff_v    = shifted_v - {1'b0, stage_r[i-1].b_mag};
            if (shifted_v >= {1'b0, stage_r[i-1].b_mag}) begin
                next_s[i].r = diff_v[DATA_LEN-1:0];
                next_s[i].q = {stage_r[i-1].q[DATA_LEN-2:0], 1'b1};
            end else begin
                next_s[i].r = shifted_v[DATA_LEN-1:0];
                next_s[i].q = {stage_r[i-1].q[DATA_LEN-2:0], 1'b0};
            end
        end
    end

    // Fix stage: restore signs, then override divide-by-zero and MIN/-1; bubbles present all zeros.
    always_comb begin
        fix_valid_s = stage_r[DATA_LEN].valid;
        fix_tag_s   = stage_r[DATA_LEN].tag;
        fix_quot_s  = stage_r[DATA_LEN].qneg ? (ZERO_VAL - stage_r[DATA_LEN].q) : stage_r[DATA_LEN].q;
        fix_rem_s   = stage_r[DATA_LEN].rneg ? (ZERO_VAL - stage_r[DATA_LEN].r) : stage_r[DATA_LEN].r;
        fix_dbz_s   = 1'b0;
        fix_ovf_s   = 1'b0;
        if (stage_r[DATA_LEN].dbz) begin
            fix_quot_s = ALL_ONES;
            fix_rem_s  = stage_r[DATA_LEN].a_raw;
            fix_dbz_s  = 1'b1;
        end else if (stage_r[DATA_LEN].ovf) begin
            fix_quot_s = stage_r[DATA_LEN].a_raw;
            fix_rem_s  = ZERO_VAL;
            fix_ovf_s  = 1'b1;
        end else begin
            fix_dbz_s  = 1'b0;
            fix_ovf_s  = 1'b0;
        end
        if (!stage_r[DATA_LEN].valid) begin
            fix_tag_s  = {TAG_LEN{1'b0}};
            fix_quot_s = ZERO_VAL;
            fix_rem_s  = ZERO_VAL;
            fix_dbz_s  = 1'b0;
            fix_ovf_s  = 1'b0;
        end else begin
            fix_valid_s = 1'b1;
        end
    end

    // Input capture, pipeline stages and output registers; reset drops every in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_valid_r <= 1'b0;
            for (int i = 0; i <= DATA_LEN; i++) begin
                stage_r[i].valid <= 1'b0;
            end
            out_valid <= 1'b0;
            out_quot  <= ZERO_VAL;
            out_rem   <= ZERO_VAL;
            out_tag   <= {TAG_LEN{1'b0}};
            out_dbz   <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (advance_s) begin
            cap_valid_r  <= in_valid;
            cap_signed_r <= in_signed;
            cap_a_r      <= in_a;
            cap_b_r      <= in_b;
            cap_tag_r    <= in_tag;
            for (int i = 0; i <= DATA_LEN; i++) begin
                stage_r[i] <= next_s[i];
            end
            out_valid <= fix_valid_s;
            out_quot  <= fix_quot_s;
            out_rem   <= fix_rem_s;
            out_tag   <= fix_tag_s;
            out_dbz   <= fix_dbz_s;
            out_ovf   <= fix_ovf_s;
        end
    end

endmodule
